// File: rtl/vga_pkg.sv
// Shared VGA constants and swap-FSM state type for the frame buffer arbiter.
// Optional test-pattern build is selected with VGA_TEST_PATTERN_EN.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned PIX_W    = 8;

  // Counter widths wide enough for a full scan including blanking
  localparam int unsigned X_W = $clog2(H_TOTAL);
  localparam int unsigned Y_W = $clog2(V_TOTAL);

  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Filter write-back stream into the arbiter: pixel writes plus the frame-done pulse.
interface vga_fb_arbiter_if import vga_pkg::*; #(
  parameter int unsigned ADDR_W = 16
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_frame_done;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_frame_done,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_frame_done,
    output wr_ready
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO buffering filter writes until the BRAM port is free.
module fb_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata_c,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_full_nx_c
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_empty;
  logic          r_full;

  logic [CW-1:0] w_cnt_nx;
  logic          w_push;
  logic          w_pop;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then
  always_comb begin
    w_pop    = i_pop && !r_empty;
    w_push   = i_push && (!r_full || w_pop);
    w_cnt_nx = r_cnt;
    if (w_push && !w_pop) begin
      w_cnt_nx = r_cnt + CW'(1);
    end else if (!w_push && w_pop) begin
      w_cnt_nx = r_cnt - CW'(1);
    end
    o_full_nx_c = (w_cnt_nx == CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_cnt   <= w_cnt_nx;
      r_empty <= (w_cnt_nx == '0);
      r_full  <= (w_cnt_nx == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata_c = r_mem[r_rptr];
  assign o_empty   = r_empty;
  assign o_full    = r_full;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame buffer port arbiter: display reads win, filter writes drain from a FIFO into the
// back bank, banks swap at vertical blanking. VGA_TEST_PATTERN_EN adds a tp_en XOR pattern.
module vga_fb_arbiter import vga_pkg::*; #(
  parameter int unsigned      IMG_W      = 256,
  parameter int unsigned      IMG_H      = 256,
  parameter int unsigned      ADDR_W     = 16,
  parameter int unsigned      WBUF_DEPTH = 4,
  parameter logic [PIX_W-1:0] BORDER     = 8'h00
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              tp_en,
`endif
  vga_fb_arbiter_if.slave   wr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              video_on_out,
  output logic              disp_bank
);

  localparam int unsigned XB   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned QW   = ADDR_W + PIX_W;

  swap_state_t r_state;
  swap_state_t w_state_nx;
  logic        w_swap;

  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W:0]   r_mem_addr;
  logic [PIX_W-1:0]  r_mem_wdata;
  logic [PIX_W-1:0]  r_pix;
  logic              r_disp_bank;
  logic              r_wr_ready;
  logic [1:0]        r_rd_d;
  logic [2:0]        r_vo_d;
  logic [2:0]        r_hs_d;
  logic [2:0]        r_vs_d;

  logic              w_in_img;
  logic              w_rd_req;
  logic              w_swap_pt;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_push;
  logic              w_pop;
  logic [QW-1:0]     w_fifo_q;
  logic [ADDR_W-1:0] w_q_addr;
  logic [PIX_W-1:0]  w_q_data;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_fifo_full_nx;

  assign w_in_img  = video_on && (x < X_W'(IMG_W)) && (y < Y_W'(IMG_H));
  assign w_swap_pt = (x == '0) && (y == Y_W'(V_ACTIVE));

`ifdef VGA_TEST_PATTERN_EN
  assign w_rd_req = w_in_img && !tp_en;
`else
  assign w_rd_req = w_in_img;
`endif

  // Power-of-two widths reduce row*IMG_W+col to a bit concatenation
  generate
    if (IMG_W == (1 << XB)) begin : g_addr_shift
      assign w_rd_addr = ADDR_W'({y, x[XB-1:0]});
    end else begin : g_addr_mul
      assign w_rd_addr = ADDR_W'(ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x));
    end
  endgenerate

  assign w_push = wr.wr_valid && r_wr_ready;
  assign w_pop  = !w_rd_req && !w_fifo_empty;
  assign {w_q_addr, w_q_data} = w_fifo_q;

  fb_wr_fifo #(
    .DEPTH (WBUF_DEPTH),
    .DW    (QW)
  ) u_wr_fifo (
    .clk         (clk25),
    .rst         (rst),
    .i_push      (w_push),
    .i_wdata     ({wr.wr_addr, wr.wr_data}),
    .i_pop       (w_pop),
    .o_rdata_c   (w_fifo_q),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full),
    .o_full_nx_c (w_fifo_full_nx)
  );

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nx;
  end

  // Swap only on an empty FIFO at the blanking point; frame_done during PENDING is dropped
  always_comb begin
    w_state_nx = r_state;
    w_swap     = 1'b0;
    case (r_state)
      RUN: begin
        if (wr.wr_frame_done) w_state_nx = PENDING;
      end
      PENDING: begin
        if (w_swap_pt && w_fifo_empty) begin
          w_state_nx = RUN;
          w_swap     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_disp_bank <= 1'b0;
      r_wr_ready  <= 1'b0;
    end else begin
      r_disp_bank <= r_disp_bank ^ w_swap;
      r_wr_ready  <= !w_fifo_full_nx && (w_state_nx == RUN);
      if (w_rd_req) begin
        r_mem_en   <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= {r_disp_bank, w_rd_addr};
      end else if (w_pop) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= 1'b1;
        r_mem_addr  <= {~r_disp_bank, w_q_addr};
        r_mem_wdata <= w_q_data;
      end else begin
        r_mem_en <= 1'b0;
        r_mem_we <= 1'b0;
      end
    end
  end

  // Three-stage alignment: address, BRAM read, pixel register
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_rd_d <= '0;
      r_vo_d <= '0;
      r_hs_d <= '1;
      r_vs_d <= '1;
    end else begin
      r_rd_d <= {r_rd_d[0], w_rd_req};
      r_vo_d <= {r_vo_d[1:0], video_on};
      r_hs_d <= {r_hs_d[1:0], hsync_in};
      r_vs_d <= {r_vs_d[1:0], vsync_in};
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [1:0]       r_tp_d;
  logic [PIX_W-1:0] r_pat_d1;
  logic [PIX_W-1:0] r_pat_d2;

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_tp_d   <= '0;
      r_pat_d1 <= '0;
      r_pat_d2 <= '0;
      r_pix    <= '0;
    end else begin
      r_tp_d   <= {r_tp_d[0], w_in_img && tp_en};
      r_pat_d1 <= x[7:0] ^ y[7:0];
      r_pat_d2 <= r_pat_d1;
      if (r_tp_d[1])      r_pix <= r_pat_d2;
      else if (r_rd_d[1]) r_pix <= mem_rdata;
      else if (r_vo_d[1]) r_pix <= BORDER;
      else                r_pix <= '0;
    end
  end
`else
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_pix <= '0;
    end else begin
      if (r_rd_d[1])      r_pix <= mem_rdata;
      else if (r_vo_d[1]) r_pix <= BORDER;
      else                r_pix <= '0;
    end
  end
`endif

  assign wr.wr_ready   = r_wr_ready;
  assign mem_en        = r_mem_en;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign pix_out       = r_pix;
  assign hsync_out     = r_hs_d[2];
  assign vsync_out     = r_vs_d[2];
  assign video_on_out  = r_vo_d[2];
  assign disp_bank     = r_disp_bank;

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port, double-banked grayscale frame buffer BRAM between two users: the VGA display fetch, driven by the timing generator's x/y/video_on, and the FIR filter's pixel write-back stream.
- Display reads have strict priority. Filter writes are buffered in a small FIFO and drained in free cycles.
- Bank swap is handshaked: the filter signals frame completion, and the swap happens only at the start of vertical blanking.
- Sits between the VGA timing generator, the filter output stage and the frame buffer BRAM.

Parameters:
- IMG_W, 256: displayed image width, placed at the top-left of the 640x480 area.
- IMG_H, 256: displayed image height.
- ADDR_W, 16: per-bank pixel address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- WBUF_DEPTH, 4: write FIFO depth; must be a power of 2.
- BORDER, 8'h00: pixel value shown outside the image region.

Ports:
- clk25  in  1  25 MHz pixel clock
- rst  in  1  asynchronous, active-high reset
- x  in  10  horizontal pixel counter from the timing generator
- y  in  10  vertical line counter from the timing generator
- video_on  in  1  active-area flag
- hsync_in  in  1  active-low horizontal sync
- vsync_in  in  1  active-low vertical sync
- wr_valid  in  1  filter write request
- wr_addr  in  ADDR_W  pixel address, computed as row*IMG_W+col
- wr_data  in  8  filtered pixel
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_frame_done  in  1  single-cycle pulse: last pixel of the current frame has been accepted
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W+1  MSB is the bank select
- mem_wdata  out  8  BRAM write data
- mem_rdata  in  8  BRAM read data; synchronous, 1-cycle latency
- pix_out  out  8  display pixel
- hsync_out  out  1  hsync delayed 3 cycles
- vsync_out  out  1  vsync delayed 3 cycles
- video_on_out  out  1  video_on delayed 3 cycles
- disp_bank  out  1  bank currently being displayed

Behaviour:
- Reset values:
  - mem_en, mem_we, mem_addr, mem_wdata = 0
  - pix_out = 0
  - hsync_out, vsync_out = 1
  - video_on_out = 0
  - disp_bank = 0
  - FIFO empty; swap_pending = 0
  - wr_ready = 1 after the first clock following reset release
- Reset mid-frame discards FIFO contents and any pending swap.
- Display request, sampled at cycle t: rd_req = video_on && x<IMG_W && y<IMG_H.
  - t+1: mem_en=1, mem_we=0, mem_addr={disp_bank, y*IMG_W+x}; multiplier-free when IMG_W is a power of 2.
  - t+3: pix_out = mem_rdata, registered.
  - If !rd_req at t: pix_out at t+3 = BORDER; if video_on was 0, pix_out = 0.
- Sync and video_on pass through a 3-stage delay so they stay aligned with pix_out.
- Write path:
  - wr_ready = !fifo_full && !swap_pending.
  - Each cycle with !rd_req and FIFO non-empty: pop, and drive mem_en=1, mem_we=1, mem_addr={~disp_bank, addr}, mem_wdata=data on the next edge.
  - Push and pop in the same cycle are both allowed, including when full (pop frees the slot first). Count logic must not wrap.
- Swap FSM has two states, RUN and PENDING.
  - RUN -> PENDING on wr_frame_done.
  - PENDING -> RUN when x==0 && y==480 && FIFO empty; disp_bank toggles in that cycle.
  - If the FIFO is non-empty at that point, the swap waits one whole frame.
  - wr_frame_done while already PENDING is ignored.
  - wr_frame_done arriving in the same cycle as the swap point still only sets PENDING; the swap needs the next frame.
- Writes always target ~disp_bank. A bank is never written while it is being displayed.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Adds input tp_en (1 bit).
  - When tp_en=1, pix_out = x[7:0]^y[7:0] for in-image pixels, using the same 3-cycle alignment.
  - Display reads are suppressed, so the write FIFO drains every cycle.
- Undefined: no tp_en port; behaviour exactly as above.

Decomposition:
- Shared package vga_pkg:
  - H_ACTIVE=640, V_ACTIVE=480, H_TOTAL=800, V_TOTAL=525
  - PIX_W=8
  - swap FSM state enum {RUN, PENDING}
- One sub-module: fb_wr_fifo, a synchronous FIFO of WBUF_DEPTH x (ADDR_W+8) with full/empty flags, used for the write buffer.

Test Plan:
- Reset:
  - Assert rst mid-frame with 3 FIFO entries queued.
  - Expect: all outputs at reset values; after release, wr_ready=1 and no stray mem_we.
- Display fetch:
  - Drive x=0..3, y=2, video_on=1, BRAM preloaded.
  - Expect mem_addr = 0x0200..0x0203 (bank 0) one cycle later, and pix_out = the matching BRAM bytes 3 cycles after each x.
- Border:
  - Drive x=300, y=10, video_on=1.
  - Expect no mem_en, and pix_out=BORDER 3 cycles later.
  - hsync_out equals hsync_in delayed 3 cycles throughout.
- FIFO backpressure:
  - Burst of 6 writes while x=0..5 lies inside the image.
  - Expect wr_ready low after 4 accepts.
  - Entries drain one per cycle starting at x=IMG_W, with mem_addr MSB=1.
  - No write is lost, and no write occurs while rd_req=1.
- Swap:
  - Pulse wr_frame_done at y=300 with the FIFO empty.
  - Expect wr_ready=0 until x=0, y=480; disp_bank goes 0->1 there; wr_ready returns to 1.
- Deferred swap:
  - Hold the FIFO non-empty (forced) at x=0, y=480.
  - Expect disp_bank unchanged, and the swap at the following frame's y=480.
